// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard/forwarding controller bundle: pipeline-register fields in, pipeline controls out.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned REG_AW      = 5,
    parameter int unsigned FLUSH_DEPTH = 2,
    parameter int unsigned CNT_W       = 32
);
    logic                   ext_stall;
    logic                   branch_taken;
    logic [REG_AW-1:0]      id_rs1;
    logic [REG_AW-1:0]      id_rs2;
    logic                   id_use_rs1;
    logic                   id_use_rs2;
    logic [REG_AW-1:0]      ex_rs1;
    logic [REG_AW-1:0]      ex_rs2;
    logic [REG_AW-1:0]      ex_rd;
    logic                   ex_regwrite;
    logic                   ex_memread;
    logic [REG_AW-1:0]      mem_rd;
    logic                   mem_regwrite;
    logic [REG_AW-1:0]      wb_rd;
    logic                   wb_regwrite;
    logic                   pc_write;
    logic                   ifid_write;
    logic                   idex_bubble;
    logic [FLUSH_DEPTH-1:0] flush;
    logic [1:0]             fwd_a;
    logic [1:0]             fwd_b;
    logic [CNT_W-1:0]       stall_cnt;
    logic [CNT_W-1:0]       flush_cnt;

    modport master (
        output ext_stall, branch_taken, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               ex_rs1, ex_rs2, ex_rd, ex_regwrite, ex_memread,
               mem_rd, mem_regwrite, wb_rd, wb_regwrite,
        input  pc_write, ifid_write, idex_bubble, flush, fwd_a, fwd_b,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  ext_stall, branch_taken, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               ex_rs1, ex_rs2, ex_rd, ex_regwrite, ex_memread,
               mem_rd, mem_regwrite, wb_rd, wb_regwrite,
        output pc_write, ifid_write, idex_bubble, flush, fwd_a, fwd_b,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard detection, load-use stall sequencing, branch flush and operand forwarding
// for the 5-stage pipeline, with saturating stall/flush event counters.
module pipe_hazard_ctrl #(
    parameter int unsigned REG_AW      = 5,
    parameter bit          FWD_EN      = 1'b1,
    parameter int unsigned LOAD_STALL  = 1,
    parameter int unsigned FLUSH_DEPTH = 2,
    parameter int unsigned CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctrl_if.slave hz
);
    localparam int unsigned     LU_W      = 4;
    localparam logic [0:0]      RUN       = 1'b0;
    localparam logic [0:0]      LU_WAIT   = 1'b1;
    localparam logic [LU_W-1:0] LU_RELOAD = LU_W'(LOAD_STALL - 1);
    localparam bit              LU_MULTI  = (LOAD_STALL > 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [0:0]             state;
    logic [0:0]             state_nxt;
    logic [LU_W-1:0]        lu_cnt;
    logic [LU_W-1:0]        lu_cnt_nxt;
    logic [CNT_W-1:0]       stall_cnt;
    logic [CNT_W-1:0]       flush_cnt;
    logic                   stall_inc;
    logic                   flush_inc;
    logic                   lu_haz;
    logic                   raw_haz;
    logic                   pc_write_c;
    logic                   ifid_write_c;
    logic                   idex_bubble_c;
    logic [FLUSH_DEPTH-1:0] flush_c;
    logic [1:0]             fwd_a_c;
    logic [1:0]             fwd_b_c;

    // A producer only matters when it writes a real register (x0 is never a hazard).
    function automatic logic reg_hit(input logic [REG_AW-1:0] src,
                                     input logic [REG_AW-1:0] rd,
                                     input logic              we);
        return we && (rd != '0) && (src == rd);
    endfunction

    // Load-use hazard always; plain RAW hazard only when forwarding is disabled.
    always_comb begin
        lu_haz  = hz.ex_memread &&
                  ((hz.id_use_rs1 && reg_hit(hz.id_rs1, hz.ex_rd, hz.ex_regwrite)) ||
                   (hz.id_use_rs2 && reg_hit(hz.id_rs2, hz.ex_rd, hz.ex_regwrite)));
        raw_haz = 1'b0;
        if (!FWD_EN) begin
            raw_haz = (hz.id_use_rs1 && (reg_hit(hz.id_rs1, hz.ex_rd,  hz.ex_regwrite) ||
                                         reg_hit(hz.id_rs1, hz.mem_rd, hz.mem_regwrite))) ||
                      (hz.id_use_rs2 && (reg_hit(hz.id_rs2, hz.ex_rd,  hz.ex_regwrite) ||
                                         reg_hit(hz.id_rs2, hz.mem_rd, hz.mem_regwrite)));
        end
    end

    // Next state and pipeline controls: ext_stall > branch_taken > stall > normal.
    always_comb begin
        state_nxt     = state;
        lu_cnt_nxt    = lu_cnt;
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;
        pc_write_c    = 1'b1;
        ifid_write_c  = 1'b1;
        idex_bubble_c = 1'b0;
        flush_c       = '0;
        if (hz.ext_stall) begin
            pc_write_c   = 1'b0;
            ifid_write_c = 1'b0;
        end else if (hz.branch_taken) begin
            flush_c    = '1;
            flush_inc  = 1'b1;
            state_nxt  = RUN;
            lu_cnt_nxt = '0;
        end else if (state == LU_WAIT) begin
            pc_write_c    = 1'b0;
            ifid_write_c  = 1'b0;
            idex_bubble_c = 1'b1;
            stall_inc     = 1'b1;
            if (lu_cnt <= LU_W'(1)) begin
                state_nxt  = RUN;
                lu_cnt_nxt = '0;
            end else begin
                lu_cnt_nxt = lu_cnt - LU_W'(1);
            end
        end else if (lu_haz || raw_haz) begin
            pc_write_c    = 1'b0;
            ifid_write_c  = 1'b0;
            idex_bubble_c = 1'b1;
            stall_inc     = 1'b1;
            if (lu_haz && LU_MULTI) begin
                state_nxt  = LU_WAIT;
                lu_cnt_nxt = LU_RELOAD;
            end
        end
        if (rst) begin
            pc_write_c    = 1'b0;
            ifid_write_c  = 1'b0;
            idex_bubble_c = 1'b0;
            flush_c       = '0;
        end
    end

    // Operand select: EX/MEM result takes precedence over MEM/WB.
    always_comb begin
        fwd_a_c = 2'b00;
        fwd_b_c = 2'b00;
        if (FWD_EN && !rst) begin
            if (reg_hit(hz.ex_rs1, hz.mem_rd, hz.mem_regwrite))     fwd_a_c = 2'b10;
            else if (reg_hit(hz.ex_rs1, hz.wb_rd, hz.wb_regwrite))  fwd_a_c = 2'b01;
            if (reg_hit(hz.ex_rs2, hz.mem_rd, hz.mem_regwrite))     fwd_b_c = 2'b10;
            else if (reg_hit(hz.ex_rs2, hz.wb_rd, hz.wb_regwrite))  fwd_b_c = 2'b01;
        end
    end

    // State, load-use countdown and saturating event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            lu_cnt    <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state  <= state_nxt;
            lu_cnt <= lu_cnt_nxt;
            if (stall_inc && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_inc && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    assign hz.pc_write    = pc_write_c;
    assign hz.ifid_write  = ifid_write_c;
    assign hz.idex_bubble = idex_bubble_c;
    assign hz.flush       = flush_c;
    assign hz.fwd_a       = fwd_a_c;
    assign hz.fwd_b       = fwd_b_c;
    assign hz.stall_cnt   = stall_cnt;
    assign hz.flush_cnt   = flush_cnt;
endmodule
